// File: rtl/dnn_feed_pkg.sv
// Shared constants and write-FSM encoding for the DNN input feeder.
package dnn_feed_pkg;

    // Network geometry
    localparam int unsigned WIDTH_IN = 8;
    localparam int unsigned N0       = 1024;
    localparam int unsigned FO0      = 8;
    localparam int unsigned Z0       = 512;
    localparam int unsigned NL       = 16;
    localparam int unsigned ZL       = 32;
    localparam int unsigned FIL      = 32;
    localparam int unsigned ETAPOS_W = 4;

    // etapos0 value presented while the read side is a bubble
    localparam logic [ETAPOS_W-1:0] BUBBLE_ETAPOS = '0;

    // Derived sizes; the configuration is only meaningful when NL == ANS_W*NW
    localparam int unsigned ACT_W = WIDTH_IN * Z0 / FO0;
    localparam int unsigned NW    = N0 * FO0 / Z0;
    localparam int unsigned CPC   = NW + 2;
    localparam int unsigned CI_W  = $clog2(CPC);
    localparam int unsigned ANS_W = ZL / FIL;
    localparam int unsigned LBL_W = $clog2(NL);
    localparam int unsigned WC_W  = $clog2(NW);

    // Write FSM encoding
    typedef logic [1:0] wstate_t;
    localparam wstate_t W_HDR  = 2'd0;
    localparam wstate_t W_ACT  = 2'd1;
    localparam wstate_t W_FULL = 2'd2;

endpackage

// File: rtl/dnn_input_feeder_if.sv
// Valid/ready word stream from the board memory path into the feeder.
interface dnn_input_feeder_if;
    import dnn_feed_pkg::*;

    logic [ACT_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/feed_bank.sv
// One sample buffer: NW activation words, label, etapos and a full flag.
// Word reads are combinational and return zero for the pipeline-fill indices.
module feed_bank
    import dnn_feed_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,        // bank is handed back to the writer
    input  logic                hdr_we,
    input  logic [LBL_W-1:0]    hdr_label,
    input  logic [ETAPOS_W-1:0] hdr_etapos,
    input  logic                word_we,
    input  logic [WC_W-1:0]     word_idx,
    input  logic                word_last,
    input  logic [ACT_W-1:0]    word_data,
    input  logic [CI_W-1:0]     rd_idx,
    output logic [ACT_W-1:0]    rd_word,
    output logic [LBL_W-1:0]    label,
    output logic [ETAPOS_W-1:0] etapos,
    output logic                full
);

    logic [ACT_W-1:0]    mem_q [NW];
    logic [LBL_W-1:0]    label_q;
    logic [ETAPOS_W-1:0] etapos_q;
    logic                full_q;

    // Activation word storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NW; i++) mem_q[i] <= '0;
        end else if (word_we) begin
            mem_q[word_idx] <= word_data;
        end
    end

    // Header fields and full flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            label_q  <= '0;
            etapos_q <= '0;
            full_q   <= 1'b0;
        end else begin
            if (hdr_we) begin
                label_q  <= hdr_label;
                etapos_q <= hdr_etapos;
            end
            if (clr) begin
                full_q <= 1'b0;
            end else if (word_we && word_last) begin
                full_q <= 1'b1;
            end
        end
    end

    // Word read; indices past the last word are the fill clocks
    always_comb begin
        rd_word = '0;
        if (rd_idx < CI_W'(NW)) rd_word = mem_q[rd_idx[WC_W-1:0]];
    end

    assign label  = label_q;
    assign etapos = etapos_q;
    assign full   = full_q;

endmodule

// File: rtl/dnn_input_feeder.sv
// DNN input feeder: accepts header + NW activation words per sample into a
// ping-pong bank pair and presents the read bank to the core in lockstep with
// cycle_index. A boundary with no complete sample yields a bubble block.
// Optional build macro DNN_FEED_STATS_EN adds saturating sample/underrun counters.
module dnn_input_feeder
    import dnn_feed_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    dnn_input_feeder_if.slave   stream,
    input  logic                cycle_clk,
    input  logic [CI_W-1:0]     cycle_index,
    output logic [ACT_W-1:0]    act0,
    output logic [ANS_W-1:0]    ans0,
    output logic [ETAPOS_W-1:0] etapos0,
    output logic                sample_live,
    output logic                underrun
`ifdef DNN_FEED_STATS_EN
    ,
    output logic [15:0]         sample_cnt,
    output logic [15:0]         underrun_cnt
`endif
);

    wstate_t         state_q, state_d;
    logic [WC_W-1:0] wc_q, wc_d;
    logic            rd_sel_q;  // bank currently read by the core; the other is written
    logic            live_q;
    logic            underrun_q;

    logic xfer, hdr_we, word_we, word_last, wr_done, wr_full, swap;

    logic [ACT_W-1:0]    rd_word0, rd_word1, rd_word;
    logic [LBL_W-1:0]    label0, label1, rd_label;
    logic [ETAPOS_W-1:0] etapos0_b0, etapos0_b1, rd_etapos;
    logic                full0, full1;

    assign stream.s_ready = !reset && (state_q != W_FULL);
    assign xfer      = stream.s_valid && stream.s_ready;
    assign hdr_we    = xfer && (state_q == W_HDR);
    assign word_we   = xfer && (state_q == W_ACT);
    assign word_last = (wc_q == WC_W'(NW - 1));
    assign wr_done   = word_we && word_last;
    assign wr_full   = rd_sel_q ? full0 : full1;
    // A sample finishing on the boundary edge itself still swaps in
    assign swap      = cycle_clk && (wr_full || wr_done);

    feed_bank u_bank0 (
        .clk        (clk),
        .reset      (reset),
        .clr        (swap && !rd_sel_q),
        .hdr_we     (hdr_we && rd_sel_q),
        .hdr_label  (stream.s_data[LBL_W-1:0]),
        .hdr_etapos (stream.s_data[LBL_W+ETAPOS_W-1:LBL_W]),
        .word_we    (word_we && rd_sel_q),
        .word_idx   (wc_q),
        .word_last  (word_last),
        .word_data  (stream.s_data),
        .rd_idx     (cycle_index),
        .rd_word    (rd_word0),
        .label      (label0),
        .etapos     (etapos0_b0),
        .full       (full0)
    );

    feed_bank u_bank1 (
        .clk        (clk),
        .reset      (reset),
        .clr        (swap && rd_sel_q),
        .hdr_we     (hdr_we && !rd_sel_q),
        .hdr_label  (stream.s_data[LBL_W-1:0]),
        .hdr_etapos (stream.s_data[LBL_W+ETAPOS_W-1:LBL_W]),
        .word_we    (word_we && !rd_sel_q),
        .word_idx   (wc_q),
        .word_last  (word_last),
        .word_data  (stream.s_data),
        .rd_idx     (cycle_index),
        .rd_word    (rd_word1),
        .label      (label1),
        .etapos     (etapos0_b1),
        .full       (full1)
    );

    // Write FSM next state; a swap always restarts at the header
    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        case (state_q)
            W_HDR: begin
                if (xfer) begin
                    state_d = W_ACT;
                    wc_d    = '0;
                end
            end
            W_ACT: begin
                if (xfer) begin
                    if (word_last) state_d = W_FULL;
                    else           wc_d    = wc_q + WC_W'(1);
                end
            end
            W_FULL:  ;
            default: state_d = W_HDR;
        endcase
        if (swap) state_d = W_HDR;
    end

    // Write FSM, bank select and boundary status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= W_HDR;
            wc_q       <= '0;
            rd_sel_q   <= 1'b0;
            live_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            underrun_q <= cycle_clk && !swap;
            if (swap) rd_sel_q <= !rd_sel_q;
            if (cycle_clk) live_q <= swap;
        end
    end

    assign rd_word   = rd_sel_q ? rd_word1   : rd_word0;
    assign rd_label  = rd_sel_q ? label1     : label0;
    assign rd_etapos = rd_sel_q ? etapos0_b1 : etapos0_b0;

    // Core-side outputs, forced to a bubble when no sample is live
    always_comb begin
        act0    = '0;
        ans0    = '0;
        etapos0 = BUBBLE_ETAPOS;
        if (live_q) begin
            act0    = rd_word;
            etapos0 = rd_etapos;
            if (cycle_index < CI_W'(NW)) begin
                for (int unsigned j = 0; j < ANS_W; j++) begin
                    ans0[j] = (32'(rd_label) == 32'(cycle_index) * ANS_W + j);
                end
            end
        end
    end

    assign sample_live = live_q;
    assign underrun    = underrun_q;

`ifdef DNN_FEED_STATS_EN
    logic [15:0] sample_cnt_q, underrun_cnt_q;

    // Saturating swap and underrun counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_cnt_q   <= '0;
            underrun_cnt_q <= '0;
        end else begin
            if (swap && sample_cnt_q != 16'hFFFF) sample_cnt_q <= sample_cnt_q + 16'd1;
            if (cycle_clk && !swap && underrun_cnt_q != 16'hFFFF) begin
                underrun_cnt_q <= underrun_cnt_q + 16'd1;
            end
        end
    end

    assign sample_cnt   = sample_cnt_q;
    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_dnn_input_feeder.sv
// Directed bench for dnn_input_feeder; emulates the cycle block counter.
`timescale 1ns/1ps
module tb_dnn_input_feeder;
    import dnn_feed_pkg::*;

    logic                clk;
    logic                reset;
    logic                cycle_clk;
    logic [CI_W-1:0]     cycle_index;
    logic [ACT_W-1:0]    act0;
    logic [ANS_W-1:0]    ans0;
    logic [ETAPOS_W-1:0] etapos0;
    logic                sample_live;
    logic                underrun;
`ifdef DNN_FEED_STATS_EN
    logic [15:0]         sample_cnt;
    logic [15:0]         underrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dnn_input_feeder_if bus ();

    dnn_input_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .stream       (bus),
        .cycle_clk    (cycle_clk),
        .cycle_index  (cycle_index),
        .act0         (act0),
        .ans0         (ans0),
        .etapos0      (etapos0),
        .sample_live  (sample_live),
        .underrun     (underrun)
`ifdef DNN_FEED_STATS_EN
        ,
        .sample_cnt   (sample_cnt),
        .underrun_cnt (underrun_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Block counter: index 0..CPC-1, strobe high during the last index
    initial begin
        cycle_index = '0;
        cycle_clk   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cycle_index == CI_W'(CPC - 1)) cycle_index = '0;
            else                               cycle_index = cycle_index + 1'b1;
            cycle_clk = (cycle_index == CI_W'(CPC - 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ACT_W-1:0] pat(input int k);
        logic [7:0] b;
        b = k[7:0];
        return {(ACT_W/8){b}};
    endfunction

    function automatic logic [ACT_W-1:0] hdr(input int lbl, input int eta);
        logic [ACT_W-1:0] w;
        w = '0;
        w[ACT_W-1:ACT_W-8]              = 8'hA5;  // junk that must be ignored
        w[LBL_W-1:0]                    = lbl[LBL_W-1:0];
        w[LBL_W+ETAPOS_W-1:LBL_W]       = eta[ETAPOS_W-1:0];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_boundary();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (cycle_index != 0 && n < 40);
        if (cycle_index != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_boundary: index %0d, required 0", cycle_index);
        end
    endtask

    // Leaves s_valid high; caller drops it when the stream should pause
    task automatic send_word(input logic [ACT_W-1:0] d);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (!bus.s_ready && n < 64) begin
            tick();
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word: s_ready stuck at 0");
        end else begin
            tick();
        end
    endtask

    task automatic send_sample(input int lbl, input int eta, input int base);
        send_word(hdr(lbl, eta));
        for (int k = 0; k < int'(NW); k++) send_word(pat(base + k));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        tick();
        tick();
        checks++; if (bus.s_ready !== 1'b0) begin errors++;
            $display("FAIL reset_s_ready: got %b required 0", bus.s_ready); end
        checks++; if (sample_live !== 1'b0) begin errors++;
            $display("FAIL reset_live: got %b required 0", sample_live); end
        checks++; if (underrun !== 1'b0) begin errors++;
            $display("FAIL reset_underrun: got %b required 0", underrun); end
        checks++; if (act0 !== '0 || ans0 !== '0) begin errors++;
            $display("FAIL reset_act_ans: act0 %0h ans0 %0h required 0", act0, ans0); end
        checks++; if (etapos0 !== BUBBLE_ETAPOS) begin errors++;
            $display("FAIL reset_etapos: got %0d required %0d", etapos0, BUBBLE_ETAPOS); end
        reset = 1'b0;
        tick();
        checks++; if (bus.s_ready !== 1'b1) begin errors++;
            $display("FAIL release_s_ready: got %b required 1", bus.s_ready); end
        for (int b = 0; b < 2; b++) begin
            wait_boundary();
            checks++; if (underrun !== 1'b1 || sample_live !== 1'b0) begin errors++;
                $display("FAIL idle_boundary%0d: underrun %b live %b required 1 0",
                         b, underrun, sample_live); end
            tick();
            checks++; if (underrun !== 1'b0 || act0 !== '0 || etapos0 !== BUBBLE_ETAPOS) begin
                errors++;
                $display("FAIL idle_block%0d: underrun %b act0 %0h etapos %0d required 0 0 %0d",
                         b, underrun, act0, etapos0, BUBBLE_ETAPOS); end
        end
    endtask

    task automatic test_single_sample();
        logic [ACT_W-1:0] exp_act;
        logic [ANS_W-1:0] exp_ans;
        wait_boundary();
        send_sample(5, 3, 0);
        bus.s_valid = 1'b0;
        checks++; if (bus.s_ready !== 1'b0 || sample_live !== 1'b0) begin errors++;
            $display("FAIL single_full: s_ready %b live %b required 0 0",
                     bus.s_ready, sample_live); end
        tick();
        for (int k = 0; k < int'(CPC); k++) begin
            exp_act = (k < int'(NW)) ? pat(k) : '0;
            exp_ans = ANS_W'(k == 5);
            checks++;
            if (act0 !== exp_act || ans0 !== exp_ans || etapos0 !== 4'd3 || sample_live !== 1'b1)
            begin
                errors++;
                $display("FAIL single_k%0d: act0 %0h ans0 %b eta %0d live %b required %0h %b 3 1",
                         k, act0, ans0, etapos0, sample_live, exp_act, exp_ans);
            end
            tick();
        end
        checks++; if (underrun !== 1'b1 || sample_live !== 1'b0) begin errors++;
            $display("FAIL single_after: underrun %b live %b required 1 0", underrun, sample_live);
        end
    endtask

    task automatic test_back_to_back();
        wait_boundary();
        send_sample(2, 1, 16);
        bus.s_data = hdr(9, 7);
        checks++; if (bus.s_ready !== 1'b0) begin errors++;
            $display("FAIL b2b_a_full: s_ready %b required 0", bus.s_ready); end
        tick();
        checks++; if (bus.s_ready !== 1'b1 || sample_live !== 1'b1 || etapos0 !== 4'd1 ||
                      act0 !== pat(16)) begin errors++;
            $display("FAIL b2b_a_live: s_ready %b live %b eta %0d act0 %0h required 1 1 1 %0h",
                     bus.s_ready, sample_live, etapos0, act0, pat(16)); end
        send_sample(9, 7, 40);
        checks++; if (bus.s_ready !== 1'b0 || etapos0 !== 4'd1 || act0 !== '0) begin errors++;
            $display("FAIL b2b_34th: s_ready %b eta %0d act0 %0h required 0 1 0",
                     bus.s_ready, etapos0, act0); end
        tick();
        bus.s_valid = 1'b0;
        checks++; if (bus.s_ready !== 1'b1 || etapos0 !== 4'd7 || act0 !== pat(40) ||
                      ans0 !== '0 || underrun !== 1'b0) begin errors++;
            $display("FAIL b2b_b_live: s_ready %b eta %0d act0 %0h ans0 %b underrun %b",
                     bus.s_ready, etapos0, act0, ans0, underrun); end
        for (int i = 0; i < 9; i++) tick();
        checks++; if (ans0 !== ANS_W'(1) || act0 !== pat(49)) begin errors++;
            $display("FAIL b2b_b_label: ans0 %b act0 %0h required 1 %0h", ans0, act0, pat(49));
        end
    endtask

    task automatic test_gap();
        wait_boundary();
        checks++; if (underrun !== 1'b1 || sample_live !== 1'b0 || etapos0 !== BUBBLE_ETAPOS ||
                      act0 !== '0) begin errors++;
            $display("FAIL gap_bubble: underrun %b live %b eta %0d act0 %0h",
                     underrun, sample_live, etapos0, act0); end
        send_sample(12, 6, 80);
        bus.s_valid = 1'b0;
        tick();
        checks++; if (underrun !== 1'b0 || sample_live !== 1'b1 || etapos0 !== 4'd6) begin
            errors++;
            $display("FAIL gap_resume: underrun %b live %b eta %0d required 0 1 6",
                     underrun, sample_live, etapos0); end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (ans0 !== ANS_W'(1) || act0 !== pat(92)) begin errors++;
            $display("FAIL gap_label: ans0 %b act0 %0h required 1 %0h", ans0, act0, pat(92)); end
    endtask

    task automatic test_last_word_on_boundary();
        wait_boundary();
        tick();
        send_sample(15, 9, 120);
        bus.s_valid = 1'b0;
        checks++; if (underrun !== 1'b0 || sample_live !== 1'b1 || etapos0 !== 4'd9 ||
                      act0 !== pat(120) || bus.s_ready !== 1'b1) begin errors++;
            $display("FAIL edge_swap: underrun %b live %b eta %0d act0 %0h s_ready %b",
                     underrun, sample_live, etapos0, act0, bus.s_ready); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (ans0 !== ANS_W'(1) || act0 !== pat(135)) begin errors++;
            $display("FAIL edge_label: ans0 %b act0 %0h required 1 %0h", ans0, act0, pat(135));
        end
    endtask

    task automatic test_reset_midfill();
        wait_boundary();
        send_word(hdr(3, 4));
        for (int k = 0; k < 7; k++) send_word(pat(200 + k));
        bus.s_valid = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (bus.s_ready !== 1'b0 || sample_live !== 1'b0) begin errors++;
            $display("FAIL midfill_reset: s_ready %b live %b required 0 0",
                     bus.s_ready, sample_live); end
        tick();
        reset = 1'b0;
        wait_boundary();
        checks++; if (underrun !== 1'b1) begin errors++;
            $display("FAIL midfill_underrun: got %b required 1", underrun); end
        send_sample(0, 2, 100);
        bus.s_valid = 1'b0;
        tick();
        checks++; if (sample_live !== 1'b1 || ans0 !== ANS_W'(1) || act0 !== pat(100) ||
                      etapos0 !== 4'd2) begin errors++;
            $display("FAIL midfill_fresh: live %b ans0 %b act0 %0h eta %0d",
                     sample_live, ans0, act0, etapos0); end
`ifdef DNN_FEED_STATS_EN
        checks++; if (sample_cnt !== 16'd1 || underrun_cnt !== 16'd1) begin errors++;
            $display("FAIL stats: sample_cnt %0d underrun_cnt %0d required 1 1",
                     sample_cnt, underrun_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_back_to_back();
        test_gap();
        test_last_word_on_boundary();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dnn_input_feeder.md
Name: dnn_input_feeder

Overview:
- Upstream stage of the DNN core. Accepts training samples as a valid/ready word stream from the board memory path.
- Buffers one complete sample in a ping-pong register bank.
- During each block cycle, presents act0, ans0 and etapos0 in lockstep with the core's cycle_clk and cycle_index.
- Outputs a bubble (zero activations, no learning) whenever no complete sample is ready at a block boundary.

Parameters:
- WIDTH_IN, 8: bits per input activation.
- N0, 1024: input-layer neurons.
- FO0, 8: fanout of the input layer.
- Z0, 512: parallelism of junction 1.
- NL, 16: output-layer neurons.
- ZL, 32: parallelism of the last junction.
- FIL, 32: fanin of the output layer.
- ETAPOS_W, 4: etapos width, equal to clog2(frac_bits+2).
- BUBBLE_ETAPOS, 0: etapos0 value driven during bubbles.
- Derived constants:
  - ACT_W = WIDTH_IN*Z0/FO0 (512)
  - NW = N0*FO0/Z0 (16 activation words per sample)
  - CPC = NW+2 (18)
  - CI_W = clog2(CPC)
  - ANS_W = ZL/FIL (1)
  - LBL_W = clog2(NL)
- Legal only if NL == ANS_W*NW.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: asynchronous, active-high.
- s_data, input, ACT_W: stream word.
- s_valid, input, 1: s_data valid.
- s_ready, output, 1: feeder accepts a word this clk.
- cycle_clk, input, 1: block-boundary strobe from cycle_block_counter.
- cycle_index, input, CI_W: clock index within the block.
- act0, output, ACT_W: activation chunk for the core.
- ans0, output, ANS_W: one-hot ideal-output slice.
- etapos0, output, ETAPOS_W: learning-rate position for the current sample.
- sample_live, output, 1: 1 when the read bank holds a real sample, 0 for a bubble.
- underrun, output, 1: one-clk pulse when a boundary finds no complete sample.

Behaviour:
- Reset is asynchronous, active-high and applies to both banks.
  - Both banks are cleared and the write FSM goes to W_HDR.
  - The read bank becomes a bubble: act0=0, ans0=0, etapos0=BUBBLE_ETAPOS, sample_live=0, underrun=0.
  - s_ready=0 while reset is high and 1 on the first clk after release.
- A word transfers on a rising clk edge where s_valid and s_ready are both 1.
- Sample format is NW+1 words:
  - Header word: s_data[LBL_W-1:0] = label (0..NL-1); s_data[LBL_W+ETAPOS_W-1:LBL_W] = etapos. Remaining bits are ignored.
  - Then activation words 0..NW-1. Word k holds activations k*ACT_W/WIDTH_IN onward, in core order; the feeder performs no reordering.
- Write FSM:
  - W_HDR: accept header, go to W_ACT with word count wc=0.
  - W_ACT: accept word wc. After wc==NW-1, go to W_FULL.
  - W_FULL: s_ready=0. Stay until a boundary.
- Boundary: a rising clk edge with cycle_clk=1.
  - If the write bank is full, or becomes full by a transfer on this same edge: swap banks, set sample_live=1, write FSM goes to W_HDR.
  - Otherwise: read bank becomes a bubble, underrun=1 for one clk, and any partial write continues undisturbed.
- Read side is combinational from the read bank and cycle_index:
  - For cycle_index k < NW: act0 = word k; ans0[j] = (label == k*ANS_W+j).
  - For k >= NW (the two pipeline-fill clocks): act0=0, ans0=0.
  - etapos0 is held constant for the whole block.
- Latency: a sample completed before boundary B is presented in the block starting at B. Minimum 1 block of buffering; the next sample can fill during the current block.
- Label >= NL: ans0 is all-zero for that sample (no error flag).
- Reset mid-fill: the partial sample is discarded; the stream source must restart at a header word.

Optional Feature:
- DNN_FEED_STATS_EN
- Defined: adds outputs sample_cnt[15:0] and underrun_cnt[15:0].
  - sample_cnt increments on each swap; underrun_cnt increments on each underrun pulse.
  - Both saturate at 0xFFFF and are cleared by reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package dnn_feed_pkg holds the derived constants (ACT_W, NW, CPC, CI_W, ANS_W, LBL_W) and a write-FSM state enum {W_HDR, W_ACT, W_FULL}.
- One sub-module: feed_bank, a single sample buffer with write port, full flag, label/etapos registers and combinational word read. Instantiated twice, with a bank-select register in the top.

Test Plan:
- Reset, then hold s_valid=0 for 2 blocks -> act0=0, ans0=0, etapos0=0, sample_live=0, underrun pulses at each boundary, s_ready=1.
- Send header {label=5, etapos=3}, then words 0..15 with word k = {64{k[7:0]}} -> in the next block, act0 = word k at cycle_index k, ans0=1 only at k=5, etapos0=3, sample_live=1; at cycle_index 16 and 17, act0=0.
- Send two samples back-to-back with s_valid stuck at 1 -> s_ready drops after the 34th word (bank full, other bank live), rises the clk after the next boundary; samples appear in order over consecutive blocks.
- No data for one block between samples -> exactly one bubble block with underrun=1 at its boundary, etapos0=BUBBLE_ETAPOS; the next sample is then presented normally.
- Last activation word accepted on the same edge as cycle_clk=1 -> swap occurs, no underrun, sample presented in the new block.
- Assert reset after 7 words of a sample, then stream a fresh complete sample {label=0} -> only the fresh sample is presented, ans0=1 at cycle_index 0; with DNN_FEED_STATS_EN defined, sample_cnt=1.
